// File: rtl/mport_ring_fifo_if.sv
// Handshake bundle for mport_ring_fifo: per-lane push/pop controls, head window and status.
// The FIFO is the slave side; the producer/consumer driving it is the master side.
interface mport_ring_fifo_if #(
   parameter int DATA  = 64,
   parameter int DEPTH = 32,
   parameter int WRITE = 4,
   parameter int READ  = 4
);
   localparam int CW = $clog2(DEPTH + 1);

   logic                        flush_;
   logic [WRITE-1:0]            we;
   logic [WRITE-1:0][DATA-1:0]  wd;
   logic [WRITE-1:0]            wrdy;
   logic [READ-1:0]             re;
   logic [READ-1:0][DATA-1:0]   rd;
   logic [READ-1:0]             v;
   logic [CW-1:0]               count;
   logic                        afull;
   logic                        busy;
   logic                        err;

   modport master (
      output flush_, we, wd, re,
      input  wrdy, rd, v, count, afull, busy, err
   );

   modport slave (
      input  flush_, we, wd, re,
      output wrdy, rd, v, count, afull, busy, err
   );
endinterface

// File: rtl/mport_ring_fifo.sv
// Multi-port in-order FIFO on a circular buffer: up to WRITE pushes and READ pops per cycle,
// with lanes packed by popcount and pointers wrapping at an arbitrary DEPTH.
module mport_ring_fifo #(
   parameter int DATA     = 64,
   parameter int DEPTH    = 32,
   parameter int WRITE    = 4,
   parameter int READ     = 4,
   parameter bit ACT      = 1'b0,
   parameter int AFULL_TH = 28
) (
   input logic            clk,
   input logic            reset_,
   mport_ring_fifo_if.slave bus
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW:0]   DEPTH_P = (PW + 1)'(DEPTH);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef logic [PW-1:0] ptr_t;
   typedef logic [CW-1:0] cnt_t;

   logic [DATA-1:0] mem [DEPTH];
   ptr_t wptr, rptr;
   cnt_t count, free;
   cnt_t wnum, rnum, acc_w, acc_r;
   logic err;

   // Offsets never exceed DEPTH, so a single conditional subtract is a full modulo.
   function automatic ptr_t wrap_add(ptr_t base, cnt_t off);
      logic [PW:0] s;
      s = {1'b0, base} + (PW + 1)'(off);
      if (s >= DEPTH_P) s = s - DEPTH_P;
      return s[PW-1:0];
   endfunction

   // NOTE: every always_comb output gets a value on every path (defaults first) so no latch is inferred.
   always_comb begin
      wnum = '0;
      rnum = '0;
      for (int i = 0; i < WRITE; i++) if (bus.we[i] == ACT) wnum = wnum + cnt_t'(1);
      for (int i = 0; i < READ; i++)  if (bus.re[i] == ACT) rnum = rnum + cnt_t'(1);
      free  = DEPTH_C - count;
      acc_w = (wnum < free)  ? wnum : free;
      acc_r = (rnum < count) ? rnum : count;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         err   <= 1'b0;
      end else if (!bus.flush_) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         err   <= 1'b0;
      end else begin
         wptr  <= wrap_add(wptr, acc_w);
         rptr  <= wrap_add(rptr, acc_r);
         count <= count + acc_w - acc_r;
         if ((wnum != acc_w) || (rnum != acc_r)) err <= 1'b1;
      end
   end

   // NOTE: storage has no reset; only the pointers and count define which entries are live.
   always_ff @(posedge clk) begin
      if (bus.flush_) begin
         for (int i = 0; i < WRITE; i++)
            if (cnt_t'(i) < acc_w) mem[wrap_add(wptr, cnt_t'(i))] <= bus.wd[i];
      end
   end

   // Status and head window come only from registered state; pushes this cycle cannot free or fill slots.
   always_comb begin
      for (int i = 0; i < READ; i++) begin
         bus.v[i]  = (count > cnt_t'(i));
         bus.rd[i] = mem[wrap_add(rptr, cnt_t'(i))];
      end
      for (int i = 0; i < WRITE; i++) bus.wrdy[i] = (free > cnt_t'(i));
      bus.count = count;
      bus.afull = (count >= cnt_t'(AFULL_TH));
      bus.busy  = (free < cnt_t'(WRITE));
      bus.err   = err;
   end
endmodule

// File: tb/tb_mport_ring_fifo.sv
// Self-checking bench: a queue-based model of two FIFO instances (DEPTH 32 and DEPTH 6)
// is compared against the DUTs every cycle, plus directed scenarios with literal expectations.
module tb_mport_ring_fifo;
   localparam int D0 = 32, TH0 = 28;
   localparam int D1 = 6,  TH1 = 5;

   logic clk = 1'b0;
   logic reset_ = 1'b0;
   always #5 clk = ~clk;

   mport_ring_fifo_if #(.DATA(64), .DEPTH(D0), .WRITE(4), .READ(4)) bb ();
   mport_ring_fifo_if #(.DATA(64), .DEPTH(D1), .WRITE(4), .READ(4)) bs ();

   mport_ring_fifo #(.DATA(64), .DEPTH(D0), .WRITE(4), .READ(4), .ACT(1'b0), .AFULL_TH(TH0))
      u_big (.clk(clk), .reset_(reset_), .bus(bb));
   mport_ring_fifo #(.DATA(64), .DEPTH(D1), .WRITE(4), .READ(4), .ACT(1'b0), .AFULL_TH(TH1))
      u_small (.clk(clk), .reset_(reset_), .bus(bs));

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: contents as a plain queue, error flag as a bit.
   logic [63:0] q0[$];
   logic [63:0] q1[$];
   bit e0, e1;

   task automatic model_step(input int id, input logic fl, input logic [3:0] we,
                             input logic [3:0][63:0] wd, input logic [3:0] re);
      logic [63:0] q[$];
      bit e;
      int depth, wnum, rnum, aw, ar;
      if (id == 0) begin q = q0; e = e0; depth = D0; end
      else         begin q = q1; e = e1; depth = D1; end
      if (!fl) begin
         q.delete();
         e = 1'b0;
      end else begin
         wnum = 0;
         rnum = 0;
         for (int i = 0; i < 4; i++) begin
            if (!we[i]) wnum++;
            if (!re[i]) rnum++;
         end
         aw = (wnum < depth - q.size()) ? wnum : depth - q.size();
         ar = (rnum < q.size()) ? rnum : q.size();
         if (aw < wnum || ar < rnum) e = 1'b1;
         repeat (ar) void'(q.pop_front());
         for (int i = 0; i < aw; i++) q.push_back(wd[i]);
      end
      if (id == 0) begin q0 = q; e0 = e; end
      else         begin q1 = q; e1 = e; end
   endtask

   always @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         q0.delete(); q1.delete();
         e0 = 1'b0; e1 = 1'b0;
      end else begin
         model_step(0, bb.flush_, bb.we, bb.wd, bb.re);
         model_step(1, bs.flush_, bs.we, bs.wd, bs.re);
      end
   end

   task automatic compare(input int id, input logic [5:0] cnt, input logic [3:0] v,
                          input logic [3:0] wrdy, input logic af, input logic bz,
                          input logic er, input logic [3:0][63:0] rd);
      logic [63:0] q[$];
      logic [3:0] v_exp, wrdy_exp;
      int depth, th, n;
      bit e;
      if (id == 0) begin q = q0; e = e0; depth = D0; th = TH0; end
      else         begin q = q1; e = e1; depth = D1; th = TH1; end
      n = q.size();
      for (int i = 0; i < 4; i++) begin
         v_exp[i]    = (n > i);
         wrdy_exp[i] = (depth - n > i);
      end
      check($sformatf("d%0d count", id), 64'(cnt), 64'(n));
      check($sformatf("d%0d v", id), 64'(v), 64'(v_exp));
      check($sformatf("d%0d wrdy", id), 64'(wrdy), 64'(wrdy_exp));
      check($sformatf("d%0d afull", id), 64'(af), 64'(n >= th));
      check($sformatf("d%0d busy", id), 64'(bz), 64'(depth - n < 4));
      check($sformatf("d%0d err", id), 64'(er), 64'(e));
      for (int i = 0; i < 4; i++)
         if (i < n) check($sformatf("d%0d rd[%0d]", id, i), rd[i], q[i]);
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         compare(0, bb.count, bb.v, bb.wrdy, bb.afull, bb.busy, bb.err, bb.rd);
         compare(1, 6'(bs.count), bs.v, bs.wrdy, bs.afull, bs.busy, bs.err, bs.rd);
      end
   end

   task automatic idle_all();
      bb.we = '1; bb.re = '1; bb.flush_ = 1'b1;
      bs.we = '1; bs.re = '1; bs.flush_ = 1'b1;
   endtask

   task automatic big_flush();
      bb.flush_ = 1'b0;
      @(negedge clk);
      bb.flush_ = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int pw0, pr0, pw1, pr1;
      idle_all();
      bb.wd = '0;
      bs.wd = '0;
      repeat (2) @(negedge clk);
      reset_ = 1'b1;
      cmp_en = 1'b1;

      // Reset state
      check("reset count", 64'(bb.count), 64'd0);
      check("reset v", 64'(bb.v), 64'h0);
      check("reset wrdy", 64'(bb.wrdy), 64'hf);
      check("reset afull", 64'(bb.afull), 64'd0);
      check("reset busy", 64'(bb.busy), 64'd0);
      check("reset err", 64'(bb.err), 64'd0);

      // Fill DEPTH 32 with 0..31, then drain 4 per cycle
      for (int c = 0; c < 8; c++) begin
         bb.we = 4'b0000;
         for (int i = 0; i < 4; i++) bb.wd[i] = 64'(4 * c + i);
         @(negedge clk);
      end
      bb.we = '1;
      check("full count", 64'(bb.count), 64'd32);
      check("full wrdy", 64'(bb.wrdy), 64'h0);
      check("full busy", 64'(bb.busy), 64'd1);
      check("full afull", 64'(bb.afull), 64'd1);
      check("full rd0", bb.rd[0], 64'd0);
      check("full rd3", bb.rd[3], 64'd3);
      for (int c = 0; c < 8; c++) begin
         bb.re = 4'b0000;
         @(negedge clk);
         if (c == 0) check("drain rd0", bb.rd[0], 64'd4);
      end
      bb.re = '1;
      check("drained count", 64'(bb.count), 64'd0);

      // Wrap on DEPTH 6
      bs.we = 4'b0000;
      for (int i = 0; i < 4; i++) bs.wd[i] = 64'(100 + i);
      @(negedge clk);
      bs.we = '1; bs.re = 4'b1000;
      @(negedge clk);
      check("wrap rd0 after pop3", bs.rd[0], 64'd103);
      bs.re = '1; bs.we = 4'b0000;
      for (int i = 0; i < 4; i++) bs.wd[i] = 64'(200 + i);
      @(negedge clk);
      check("wrap count5", 64'(bs.count), 64'd5);
      check("wrap rd4", bs.rd[3], 64'd202);
      bs.we = '1; bs.re = 4'b0000;
      @(negedge clk);
      check("wrap rd0 after pop4", bs.rd[0], 64'd203);
      bs.re = 4'b1110;
      @(negedge clk);
      bs.re = '1;
      check("wrap count0", 64'(bs.count), 64'd0);
      check("wrap err", 64'(bs.err), 64'd0);

      // Overflow at 30 of 32, then push+pop at full uses pre-pop space only
      big_flush();
      for (int c = 0; c < 8; c++) begin
         bb.we = (c == 7) ? 4'b1100 : 4'b0000;
         for (int i = 0; i < 4; i++) bb.wd[i] = 64'(1000 + 4 * c + i);
         @(negedge clk);
      end
      check("ovf count30", 64'(bb.count), 64'd30);
      bb.we = 4'b0000;
      @(negedge clk);
      check("ovf count32", 64'(bb.count), 64'd32);
      check("ovf err", 64'(bb.err), 64'd1);
      bb.we = 4'b1100; bb.re = 4'b1100;
      @(negedge clk);
      bb.we = '1; bb.re = '1;
      check("full push+pop count", 64'(bb.count), 64'd30);
      check("full push+pop err sticky", 64'(bb.err), 64'd1);

      // Underflow on empty, flush clears err
      big_flush();
      bb.re = 4'b0000;
      @(negedge clk);
      bb.re = '1;
      check("udf v", 64'(bb.v), 64'h0);
      check("udf count", 64'(bb.count), 64'd0);
      check("udf err", 64'(bb.err), 64'd1);
      big_flush();
      check("flush err", 64'(bb.err), 64'd0);

      // Sparse active-low lanes
      bb.we = 4'b0101;
      bb.wd[0] = 64'hAAAA; bb.wd[1] = 64'hBBBB; bb.wd[2] = 64'hCCCC; bb.wd[3] = 64'hDDDD;
      @(negedge clk);
      bb.we = '1;
      check("sparse count", 64'(bb.count), 64'd2);
      check("sparse rd0", bb.rd[0], 64'hAAAA);
      check("sparse rd1", bb.rd[1], 64'hBBBB);

      // Asynchronous reset mid-burst at 17
      big_flush();
      for (int c = 0; c < 5; c++) begin
         bb.we = (c == 4) ? 4'b1110 : 4'b0000;
         for (int i = 0; i < 4; i++) bb.wd[i] = 64'(2000 + 4 * c + i);
         @(negedge clk);
      end
      check("pre-reset count", 64'(bb.count), 64'd17);
      bb.we = 4'b0000;
      @(posedge clk);
      #2;
      reset_ = 1'b0;
      #1;
      check("async rst count", 64'(bb.count), 64'd0);
      check("async rst v", 64'(bb.v), 64'h0);
      check("async rst wrdy", 64'(bb.wrdy), 64'hf);
      bb.we = '1;
      @(negedge clk);
      reset_ = 1'b1;
      bb.flush_ = 1'b0; bb.we = 4'b0000;
      @(negedge clk);
      bb.flush_ = 1'b1; bb.we = '1;
      check("flush+push count", 64'(bb.count), 64'd0);

      // Randomized traffic on both instances
      pw0 = 50; pr0 = 50; pw1 = 50; pr1 = 50;
      for (int c = 0; c < 3000; c++) begin
         if (c % 50 == 0) begin
            pw0 = 15 + 35 * $urandom_range(0, 2); pr0 = 15 + 35 * $urandom_range(0, 2);
            pw1 = 15 + 35 * $urandom_range(0, 2); pr1 = 15 + 35 * $urandom_range(0, 2);
         end
         for (int i = 0; i < 4; i++) begin
            bb.we[i] = !($urandom_range(0, 99) < pw0);
            bb.re[i] = !($urandom_range(0, 99) < pr0);
            bs.we[i] = !($urandom_range(0, 99) < pw1);
            bs.re[i] = !($urandom_range(0, 99) < pr1);
            bb.wd[i] = {$urandom, $urandom};
            bs.wd[i] = {$urandom, $urandom};
         end
         bb.flush_ = ($urandom_range(0, 99) != 0);
         bs.flush_ = ($urandom_range(0, 99) != 0);
         @(negedge clk);
      end
      idle_all();
      @(negedge clk);
      cmp_en = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
